// File: rtl/tx_source_switch_if.sv
// Shared transmit-chain constants and the bus interfaces used by tx_source_switch:
// a parallel realtime data bus and an AXI-stream style config channel.
package tx_pkg;
  parameter int PARALLEL_SAMPLES = 2;
  parameter int SAMPLE_WIDTH     = 8;
  parameter int DATA_WIDTH       = PARALLEL_SAMPLES * SAMPLE_WIDTH;
  parameter int CHANNELS         = 2;
endpackage

interface Realtime_Parallel_If #(
  parameter int DWIDTH   = 16,
  parameter int CHANNELS = 1
);
  logic [CHANNELS-1:0][DWIDTH-1:0] data;
  logic [CHANNELS-1:0]             valid;

  modport Master (output data, output valid);
  modport Slave  (input  data, input  valid);
endinterface

interface Axis_If #(
  parameter int DWIDTH = 8
);
  logic [DWIDTH-1:0] data;
  logic              valid;
  logic              ready;

  modport Master (output data, output valid, input  ready);
  modport Slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/tx_source_switch.sv
// Per-channel generator source selector: switches immediately or on the routed
// source's trigger, then blanks the channel for BLANK_CYCLES while it settles.
module tx_source_switch #(
  parameter int SOURCES      = 3,
  parameter int CHANNELS     = tx_pkg::CHANNELS,
  parameter int DWIDTH       = tx_pkg::DATA_WIDTH,
  parameter int BLANK_CYCLES = 4,
  parameter int SEL_BITS     = $clog2(SOURCES)
) (
  input  logic                      dac_clk,
  input  logic                      dac_reset,
  Realtime_Parallel_If.Slave        data_in,
  input  logic [SOURCES*CHANNELS-1:0] triggers_in,
  Axis_If.Slave                     config_in,
  Realtime_Parallel_If.Master       data_out,
  output logic [CHANNELS-1:0]       triggers_out,
  output logic [CHANNELS-1:0]       pending_out
);

  localparam int NIN = SOURCES * CHANNELS;
  localparam int FW  = SEL_BITS + 1;
  localparam int IW  = (NIN > 1) ? $clog2(NIN) : 1;
  localparam int CW  = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES);

  logic [NIN-1:0][DWIDTH-1:0]        cap_data_r;
  logic [NIN-1:0]                    cap_valid_r;
  logic [NIN-1:0]                    cap_trig_r;

  logic [CHANNELS-1:0][SEL_BITS-1:0] cur_sel_r, cur_sel_s;
  logic [CHANNELS-1:0][SEL_BITS-1:0] pend_sel_r, pend_sel_s;
  logic [CHANNELS-1:0]               pend_mode_r, pend_mode_s;
  logic [CHANNELS-1:0]               pending_r, pending_s;
  logic [CHANNELS-1:0]               fresh_r, fresh_s;
  logic [CHANNELS-1:0][CW-1:0]       blank_cnt_r, blank_cnt_s;

  logic [CHANNELS-1:0]               legal_s;
  logic [CHANNELS-1:0][IW-1:0]       src_idx_s;
  logic [CHANNELS-1:0]               src_trig_s;
  logic [CHANNELS-1:0]               apply_s;
  logic                              ready_s;
  logic                              accept_s;

  logic [CHANNELS-1:0][DWIDTH-1:0]   out_data_s;
  logic [CHANNELS-1:0]               out_valid_s;
  logic [CHANNELS-1:0]               out_trig_s;

  assign ready_s         = ~|pending_r;
  assign accept_s        = config_in.valid & ready_s;
  assign config_in.ready = ready_s;
  assign pending_out     = pending_r;

  // Stage 1: capture every source word, valid and trigger.
  always_ff @(posedge dac_clk or posedge dac_reset) begin
    if (dac_reset) begin
      cap_data_r  <= '0;
      cap_valid_r <= '0;
      cap_trig_r  <= '0;
    end else begin
      cap_data_r  <= data_in.data;
      cap_valid_r <= data_in.valid;
      cap_trig_r  <= triggers_in;
    end
  end

  // Decode the routed source index per channel; illegal codes mute the channel.
  always_comb begin
    legal_s    = '0;
    src_idx_s  = '0;
    src_trig_s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (int'(cur_sel_r[c]) < SOURCES) begin
        legal_s[c]    = 1'b1;
        src_idx_s[c]  = IW'(int'(cur_sel_r[c]) * CHANNELS + c);
        src_trig_s[c] = cap_trig_r[src_idx_s[c]];
      end else begin
        legal_s[c]    = 1'b0;
        src_idx_s[c]  = '0;
        src_trig_s[c] = 1'b0;
      end
    end
  end

  // A pending switch applies on its first pending cycle (immediate) or once the
  // routed source triggers after the accept cycle (fresh_r masks that cycle).
  always_comb begin
    apply_s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      apply_s[c] = pending_r[c] & (~pend_mode_r[c] | (~fresh_r[c] & src_trig_s[c]));
    end
  end

  // Switch state register.
  always_ff @(posedge dac_clk or posedge dac_reset) begin
    if (dac_reset) begin
      cur_sel_r   <= '0;
      pend_sel_r  <= '0;
      pend_mode_r <= '0;
      pending_r   <= '0;
      fresh_r     <= '0;
      blank_cnt_r <= '0;
    end else begin
      cur_sel_r   <= cur_sel_s;
      pend_sel_r  <= pend_sel_s;
      pend_mode_r <= pend_mode_s;
      pending_r   <= pending_s;
      fresh_r     <= fresh_s;
      blank_cnt_r <= blank_cnt_s;
    end
  end

  // Next switch state: IDLE -> WAIT (pending) -> BLANK (counter) -> IDLE.
  always_comb begin
    cur_sel_s   = cur_sel_r;
    pend_sel_s  = pend_sel_r;
    pend_mode_s = pend_mode_r;
    pending_s   = pending_r;
    fresh_s     = '0;
    blank_cnt_s = blank_cnt_r;
    for (int c = 0; c < CHANNELS; c++) begin
      if (apply_s[c]) begin
        cur_sel_s[c]   = pend_sel_r[c];
        pending_s[c]   = 1'b0;
        blank_cnt_s[c] = BLANK_LOAD;
      end else if (blank_cnt_r[c] != '0) begin
        blank_cnt_s[c] = blank_cnt_r[c] - CW'(1);
      end else begin
        blank_cnt_s[c] = blank_cnt_r[c];
      end
      if (accept_s && (config_in.data[c*FW +: SEL_BITS] != cur_sel_r[c])) begin
        pending_s[c]   = 1'b1;
        pend_sel_s[c]  = config_in.data[c*FW +: SEL_BITS];
        pend_mode_s[c] = config_in.data[c*FW + SEL_BITS];
        fresh_s[c]     = 1'b1;
      end else begin
        fresh_s[c]     = 1'b0;
      end
    end
  end

  // Route, blank and mute; the apply-cycle trigger is dropped as it belongs to the old source.
  always_comb begin
    out_data_s  = '0;
    out_valid_s = '0;
    out_trig_s  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (legal_s[c]) begin
        out_valid_s[c] = cap_valid_r[src_idx_s[c]];
        if (blank_cnt_r[c] == '0) begin
          out_data_s[c] = cap_data_r[src_idx_s[c]];
          out_trig_s[c] = src_trig_s[c] & ~apply_s[c];
        end else begin
          out_data_s[c] = '0;
          out_trig_s[c] = 1'b0;
        end
      end else begin
        out_data_s[c]  = '0;
        out_valid_s[c] = 1'b0;
        out_trig_s[c]  = 1'b0;
      end
    end
  end

  // Stage 2: output register.
  always_ff @(posedge dac_clk or posedge dac_reset) begin
    if (dac_reset) begin
      data_out.data  <= '0;
      data_out.valid <= '0;
      triggers_out   <= '0;
    end else begin
      data_out.data  <= out_data_s;
      data_out.valid <= out_valid_s;
      triggers_out   <= out_trig_s;
    end
  end

endmodule

// File: tb/tb_tx_source_switch.sv
// Randomised bench for tx_source_switch, checked against a cycle-history model
// that derives selection, blank windows and trigger drops from switch events.
module tb_tx_source_switch;

  localparam int S    = 3;
  localparam int C    = 2;
  localparam int W    = 16;
  localparam int B    = 4;
  localparam int SB   = 2;
  localparam int FW   = SB + 1;
  localparam int NIN  = S * C;
  localparam int MAXK = 4096;

  logic           clk;
  logic           rst;
  logic [NIN-1:0] trig_in;
  logic [C-1:0]   trig_out;
  logic [C-1:0]   pend_out;

  Realtime_Parallel_If #(.DWIDTH(W), .CHANNELS(NIN)) din_if();
  Realtime_Parallel_If #(.DWIDTH(W), .CHANNELS(C))   dout_if();
  Axis_If #(.DWIDTH(C*FW))                           cfg_if();

  tx_source_switch #(.SOURCES(S), .CHANNELS(C), .DWIDTH(W), .BLANK_CYCLES(B)) dut (
    .dac_clk      (clk),
    .dac_reset    (rst),
    .data_in      (din_if),
    .triggers_in  (trig_in),
    .config_in    (cfg_if),
    .data_out     (dout_if),
    .triggers_out (trig_out),
    .pending_out  (pend_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // model state: current selection and the switch waiting on each channel
  int k;
  int cur[C];
  bit pend[C];
  int psel[C];
  bit pmode[C];
  int acc_cyc[C];

  // per-cycle history since the last reset release
  logic [W-1:0] din_h[MAXK][NIN];
  bit           vin_h[MAXK][NIN];
  bit           tin_h[MAXK][NIN];
  int           sel_h[MAXK][C];
  bit           app_h[MAXK][C];

  int             trig_pct;
  logic [NIN-1:0] force_trig;
  bit             cfg_req;
  logic [C*FW-1:0] cfg_word;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    k = 0;
    for (int c = 0; c < C; c++) begin
      cur[c]     = 0;
      pend[c]    = 1'b0;
      psel[c]    = 0;
      pmode[c]   = 1'b0;
      acc_cyc[c] = 0;
    end
  endtask

  task automatic step();
    bit          rdy;
    bit          blank;
    bit          app;
    int          m;
    int          s;
    int          idx;
    int          fs;
    logic [W-1:0] ed;
    bit          ev;
    bit          et;
    @(posedge clk);
    #1;
    if (k >= MAXK) begin
      $display("FAIL history_overflow: got %0d expected below %0d", k, MAXK);
      $fatal(1, "history overflow");
    end
    // compare outputs of cycle k with what inputs of k-2 and state of k-1 imply
    rdy = 1'b1;
    for (int c = 0; c < C; c++) begin
      ed = '0;
      ev = 1'b0;
      et = 1'b0;
      if (k >= 2) begin
        m = k - 1;
        s = sel_h[m][c];
        blank = 1'b0;
        for (int a = m - B; a < m; a++) begin
          if (a >= 0 && app_h[a][c]) blank = 1'b1;
        end
        if (s < S) begin
          idx = s * C + c;
          ev  = vin_h[k-2][idx];
          ed  = blank ? '0 : din_h[k-2][idx];
          et  = tin_h[k-2][idx] && !blank && !app_h[m][c];
        end
      end
      if (k != 1) begin
        check_value($sformatf("data ch%0d k%0d", c, k), 32'(dout_if.data[c]), 32'(ed));
        check_value($sformatf("valid ch%0d k%0d", c, k), 32'(dout_if.valid[c]), 32'(ev));
        check_value($sformatf("trig ch%0d k%0d", c, k), 32'(trig_out[c]), 32'(et));
      end
      check_value($sformatf("pending ch%0d k%0d", c, k), 32'(pend_out[c]), 32'(pend[c]));
      if (pend[c]) rdy = 1'b0;
    end
    check_value($sformatf("ready k%0d", k), 32'(cfg_if.ready), 32'(rdy));

    // drive cycle k
    for (int i = 0; i < NIN; i++) begin
      din_if.data[i]  = W'($urandom);
      din_if.valid[i] = ($urandom_range(0, 9) != 0);
      trig_in[i]      = (int'($urandom_range(0, 99)) < trig_pct) | force_trig[i];
      din_h[k][i]     = din_if.data[i];
      vin_h[k][i]     = din_if.valid[i];
      tin_h[k][i]     = trig_in[i];
    end
    cfg_if.valid = cfg_req;
    cfg_if.data  = cfg_word;

    // advance the model through cycle k
    for (int c = 0; c < C; c++) begin
      sel_h[k][c] = cur[c];
      app = 1'b0;
      if (pend[c]) begin
        if (!pmode[c]) app = 1'b1;
        else if (k - 1 > acc_cyc[c] && cur[c] < S && tin_h[k-1][cur[c]*C + c]) app = 1'b1;
      end
      app_h[k][c] = app;
      if (app) begin
        cur[c]  = psel[c];
        pend[c] = 1'b0;
      end
    end
    if (cfg_req && rdy) begin
      for (int c = 0; c < C; c++) begin
        fs = int'(cfg_word[c*FW +: SB]);
        if (fs != cur[c]) begin
          pend[c]    = 1'b1;
          psel[c]    = fs;
          pmode[c]   = cfg_word[c*FW + SB];
          acc_cyc[c] = k;
        end
      end
      cfg_req = 1'b0;
    end
    k++;
  endtask

  task automatic issue(input logic [C*FW-1:0] w);
    int budget;
    cfg_req  = 1'b1;
    cfg_word = w;
    budget   = 50;
    while (cfg_req && budget > 0) begin
      step();
      budget--;
    end
    if (cfg_req) begin
      check_value("cfg_accept_timeout", 32'(1), 32'(0));
      cfg_req = 1'b0;
    end
  endtask

  task automatic async_reset_check(input string tag);
    #3;
    rst = 1'b1;
    #1;
    for (int c = 0; c < C; c++) begin
      check_value($sformatf("%s rst data ch%0d", tag, c), 32'(dout_if.data[c]), 32'(0));
      check_value($sformatf("%s rst valid ch%0d", tag, c), 32'(dout_if.valid[c]), 32'(0));
      check_value($sformatf("%s rst trig ch%0d", tag, c), 32'(trig_out[c]), 32'(0));
      check_value($sformatf("%s rst pending ch%0d", tag, c), 32'(pend_out[c]), 32'(0));
    end
    cfg_req      = 1'b0;
    cfg_if.valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_value($sformatf("%s post ready", tag), 32'(cfg_if.ready), 32'(1));
    check_value($sformatf("%s post pending", tag), 32'(pend_out), 32'(0));
  endtask

  initial begin
    logic [C*FW-1:0] w;
    int              fs;
    bit              fm;
    bit              any_pend;
    rst          = 1'b1;
    trig_in      = '0;
    din_if.data  = '0;
    din_if.valid = '0;
    cfg_if.valid = 1'b0;
    cfg_if.data  = '0;
    force_trig   = '0;
    cfg_req      = 1'b0;
    cfg_word     = '0;
    trig_pct     = 10;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_value("reset data", 32'(dout_if.data), 32'(0));
    check_value("reset trig", 32'(trig_out), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    check_value("reset ready", 32'(cfg_if.ready), 32'(1));

    repeat (8) step();
    // immediate ch0 -> source 1, ch1 stays on source 0
    issue({3'b000, 3'b001});
    repeat (10) step();

    // on-trigger ch1 -> source 2, with a second word held while not ready
    trig_pct = 0;
    issue({3'b110, 3'b001});
    cfg_req  = 1'b1;
    cfg_word = {3'b010, 3'b001};
    repeat (6) step();
    force_trig = 6'b000010;
    step();
    force_trig = '0;
    for (int i = 0; i < 20 && cfg_req; i++) step();
    check_value("held_word_accepted", 32'(cfg_req), 32'(0));
    trig_pct = 10;
    repeat (10) step();

    // illegal code mutes ch0, then source 0 returns after blanking
    issue({3'b010, 3'b011});
    repeat (8) step();
    issue({3'b010, 3'b000});
    repeat (10) step();

    // reset in the middle of a trigger wait
    trig_pct = 0;
    issue({3'b010, 3'b101});
    repeat (3) step();
    async_reset_check("wait");
    trig_pct = 10;
    repeat (6) step();

    // reset in the middle of a blank interval
    issue({3'b001, 3'b000});
    repeat (2) step();
    async_reset_check("blank");
    repeat (6) step();

    // random configs, only offered when nothing is pending
    trig_pct = 15;
    repeat (1500) begin
      any_pend = 1'b0;
      for (int c = 0; c < C; c++) if (pend[c]) any_pend = 1'b1;
      if (!cfg_req && !any_pend && $urandom_range(0, 19) == 0) begin
        for (int c = 0; c < C; c++) begin
          fs = int'($urandom_range(0, 3));
          fm = 1'($urandom_range(0, 1));
          if (cur[c] >= S) fm = 1'b0;
          w[c*FW +: FW] = {fm, SB'(fs)};
        end
        cfg_req  = 1'b1;
        cfg_word = w;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
